// File: rtl/logic15_pkg.sv
// Shared definitions for the 15-bit logic arbiter: operand width, op codes,
// FSM state encoding and the And15 gate-array primitive.
package logic15_pkg;

   localparam int W = 15;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_ANDN = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Bitwise model of the And15 gate array; every op is derived from it.
   function automatic logic [W-1:0] and15(input logic [W-1:0] x, input logic [W-1:0] y);
      return x & y;
   endfunction

endpackage

// File: rtl/logic15_unit.sv
// Combinational 15-bit logic unit: AND, OR, XOR and ANDN built only from
// And15 arrays, inverters and one OR of two And15 outputs.
module logic15_unit
   import logic15_pkg::*;
(
   input  logic [1:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   logic [W-1:0] and_ab;
   logic [W-1:0] and_nn;
   logic [W-1:0] and_anb;
   logic [W-1:0] and_nab;

   assign and_ab  = and15(a, b);
   assign and_nn  = and15(~a, ~b);
   assign and_anb = and15(a, ~b);
   assign and_nab = and15(~a, b);

   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = and_ab;
         OP_OR:   y = ~and_nn;
         OP_XOR:  y = and_anb | and_nab;
         OP_ANDN: y = and_anb;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/logic15_arbiter.sv
// Round-robin arbiter sharing one logic15_unit among NREQ requesters.
// Define LOGIC15_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
//
// state   | meaning
// IDLE    | search req from ptr, grant winner and capture its operands
// EXEC    | load result register from the unit (one cycle)
// RESP    | hold rsp_valid/rsp_id/rsp_data until rsp_ready
module logic15_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int W    = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] a_in,
   input  logic [NREQ*W-1:0] b_in,
   input  logic [NREQ*2-1:0] op_in,
   output logic [NREQ-1:0]   gnt,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_data,
   input  logic              rsp_ready,
   output logic [15:0]       done_cnt
);
   import logic15_pkg::*;

   state_e         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] id_q, id_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [1:0]     op_q, op_d;
   logic [W-1:0]   data_q, data_d;
   logic [15:0]    done_q, done_d;

   logic           pick_found;
   logic [IDW-1:0] pick_idx;
   int             cand;
   logic [W-1:0]   unit_y;

   logic15_unit u_unit (
      .op (op_q),
      .a  (a_q),
      .b  (b_q),
      .y  (unit_y)
   );

   // First asserted req, scanning upward from the search start with wrap.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int k = 0; k < NREQ; k++) begin
`ifdef LOGIC15_ARB_FIXED_PRIO_EN
         cand = k;
`else
         cand = (int'(ptr_q) + k) % NREQ;
`endif
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = IDW'(cand);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      data_d  = data_q;
      done_d  = done_q;
      gnt     = '0;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               gnt[pick_idx] = 1'b1;
               id_d    = pick_idx;
               a_d     = a_in[int'(pick_idx)*W +: W];
               b_d     = b_in[int'(pick_idx)*W +: W];
               op_d    = op_in[int'(pick_idx)*2 +: 2];
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            data_d  = unit_y;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
`ifdef LOGIC15_ARB_FIXED_PRIO_EN
               ptr_d = '0;
`else
               ptr_d = IDW'((int'(id_q) + 1) % NREQ);
`endif
               done_d  = done_q + 16'd1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         data_q  <= '0;
         done_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_id    = id_q;
   assign rsp_data  = data_q;
   assign done_cnt  = done_q;

endmodule

// File: tb/tb_logic15_arbiter.sv
// Self-checking bench for logic15_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_logic15_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int W    = 15;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] a_in;
   logic [NREQ*W-1:0] b_in;
   logic [NREQ*2-1:0] op_in;
   logic [NREQ-1:0]   gnt;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_data;
   logic              rsp_ready;
   logic [15:0]       done_cnt;

   always #5 clk = ~clk;

   logic15_arbiter #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .op_in     (op_in),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_ready (rsp_ready),
      .done_cnt  (done_cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Transaction model: age = cycles since the grant (-1 when no operation).
   int          m_age  = -1;
   int          m_ptr  = 0;
   int          m_id   = 0;
   logic [14:0] m_data = '0;
   logic [15:0] m_done = '0;
   logic [NREQ-1:0] last_gnt = '0;

   function automatic logic [14:0] mf(input logic [1:0] op, input logic [14:0] a, input logic [14:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return a & ~b;
      endcase
   endfunction

   function automatic int m_winner();
      for (int k = 0; k < NREQ; k++) begin
`ifdef LOGIC15_ARB_FIXED_PRIO_EN
         if (req[k]) return k;
`else
         if (req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
`endif
      end
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare();
      int w;
      logic [31:0] exp_gnt;
      w = m_winner();
      exp_gnt = (m_age < 0 && w >= 0) ? (32'd1 << w) : 32'd0;
      chk("gnt", 32'(gnt), exp_gnt);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_age >= 1));
      chk("done_cnt", 32'(done_cnt), 32'(m_done));
      if (m_age >= 1) begin
         chk("rsp_id", 32'(rsp_id), 32'(m_id));
         chk("rsp_data", 32'(rsp_data), 32'(m_data));
      end
      last_gnt = gnt;
   endtask

   task automatic model_step();
      int w;
      if (reset) begin
         m_age  = -1;
         m_ptr  = 0;
         m_done = '0;
      end else if (m_age < 0) begin
         w = m_winner();
         if (w >= 0) begin
            m_age  = 0;
            m_id   = w;
            m_data = mf(op_in[w*2 +: 2], a_in[w*W +: W], b_in[w*W +: W]);
         end
      end else if (m_age == 0) begin
         m_age = 1;
      end else if (rsp_ready) begin
         m_age = -1;
`ifdef LOGIC15_ARB_FIXED_PRIO_EN
         m_ptr = 0;
`else
         m_ptr = (m_id + 1) % NREQ;
`endif
         m_done = m_done + 16'd1;
      end
   endtask

   task automatic tick();
      #1;
      compare();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic set_op(input int i, input logic [14:0] a, input logic [14:0] b, input logic [1:0] op);
      a_in[i*W +: W] = a;
      b_in[i*W +: W] = b;
      op_in[i*2 +: 2] = op;
   endtask

   task automatic wait_grant(input string nm);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (last_gnt == '0 && n < 20);
      if (last_gnt == '0) chk({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic do_op(input int idx, input logic [14:0] a, input logic [14:0] b,
                        input logic [1:0] op, input logic [14:0] exp);
      logic [NREQ-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      set_op(idx, a, b, op);
      req = oh;
      rsp_ready = 1'b1;
      wait_grant("op_grant");
      chk("op_gnt", 32'(last_gnt), 32'(oh));
      req = '0;
      tick();
      #1;
      chk("op_valid", 32'(rsp_valid), 32'd1);
      chk("op_data", 32'(rsp_data), 32'(exp));
      chk("op_id", 32'(rsp_id), 32'(idx));
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int gseq[$];
      int exp_seq[$];
      logic [14:0] d0;
      logic [IDW-1:0] i0;
      logic [15:0] done0;

      reset = 1'b1;
      req = '0;
      a_in = '0;
      b_in = '0;
      op_in = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_done", 32'(done_cnt), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);

      // Single AND from requester 0
      do_op(0, 15'h7FFF, 15'h1234, 2'b00, 15'h1234);
      #1;
      chk("done_after_first", 32'(done_cnt), 32'd1);

      // Every op through requester 2
      do_op(2, 15'h5555, 15'h7F00, 2'b00, 15'h5500);
      do_op(2, 15'h5555, 15'h7F00, 2'b01, 15'h7F55);
      do_op(2, 15'h5555, 15'h7F00, 2'b10, 15'h2A55);
      do_op(2, 15'h5555, 15'h7F00, 2'b11, 15'h0055);
      #1;
      chk("done_after_five", 32'(done_cnt), 32'd5);

      // All requesters held high: grant order
      do_reset();
      req = '1;
      rsp_ready = 1'b1;
      for (int n = 0; n < 40 && gseq.size() < 5; n++) begin
         tick();
         for (int i = 0; i < NREQ; i++) if (last_gnt[i]) gseq.push_back(i);
      end
`ifdef LOGIC15_ARB_FIXED_PRIO_EN
      exp_seq = '{0, 0, 0};
`else
      exp_seq = '{0, 1, 2, 3, 0};
`endif
      for (int i = 0; i < exp_seq.size(); i++)
         chk("grant_order", (i < gseq.size()) ? 32'(gseq[i]) : 32'hFFFF_FFFF, 32'(exp_seq[i]));
      req = '0;
      for (int n = 0; n < 4; n++) tick();

      // Backpressure in RESP
      do_reset();
      set_op(0, 15'h0F0F, 15'h00FF, 2'b10);
      set_op(1, 15'h1111, 15'h2222, 2'b01);
      req = 4'b0001;
      rsp_ready = 1'b0;
      wait_grant("bp_grant");
      req = 4'b0011;
      tick();
      #1;
      d0 = rsp_data;
      i0 = rsp_id;
      chk("bp_data", 32'(d0), 32'h0FF0);
      chk("bp_id", 32'(i0), 32'd0);
      for (int n = 0; n < 5; n++) begin
         #1;
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_data_stable", 32'(rsp_data), 32'(d0));
         chk("bp_id_stable", 32'(rsp_id), 32'(i0));
         chk("bp_gnt_zero", 32'(gnt), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      #1;
      chk("bp_done", 32'(done_cnt), 32'd1);
      chk("bp_valid_fall", 32'(rsp_valid), 32'd0);
      tick();
`ifdef LOGIC15_ARB_FIXED_PRIO_EN
      chk("bp_next_gnt", 32'(last_gnt), 32'b0001);
`else
      chk("bp_next_gnt", 32'(last_gnt), 32'b0010);
`endif

      // Reset during EXEC aborts the operation
      done0 = done_cnt;
      chk("pre_abort_done", 32'(done0 != 16'd0), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("abort_valid", 32'(rsp_valid), 32'd0);
      chk("abort_done", 32'(done_cnt), 32'd0);
      chk("abort_regrant", 32'(gnt), 32'b0001);
      req = '0;
      for (int n = 0; n < 5; n++) tick();

      // Randomized traffic
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 299) == 0);
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (last_gnt[i]) req[i] = ($urandom_range(0, 3) == 0);
            else if (!req[i]) req[i] = ($urandom_range(0, 2) == 0);
            a_in[i*W +: W] = 15'($urandom);
            b_in[i*W +: W] = 15'($urandom);
         end
         op_in = 8'($urandom);
         tick();
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
